// File: rtl/midi_voice_alloc.sv
// Polyphonic MIDI voice allocator: decodes note-on/off/all-notes-off for one channel, assigns LRU voices.
// Define VOICE_STEAL_EN to let a note-on with no matching or free voice take over the oldest voice.
module midi_voice_alloc #(
    parameter int N_VOICES   = 4,
    parameter int PHASE_BITS = 32,
    parameter int CHANNEL    = 0,
    parameter int OMNI       = 0
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           midi_valid_in,
    input  logic [23:0]                    midi_event_in,
    output logic                           ready_out,
    output logic                           overflow_out,
    output logic [N_VOICES-1:0]            gate_out,
    output logic [N_VOICES*7-1:0]          note_out,
    output logic [N_VOICES*8-1:0]          vol_out,
    output logic [N_VOICES*PHASE_BITS-1:0] phase_incr_out
);

    localparam int IDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic [1:0] EV_ON  = 2'd0;
    localparam logic [1:0] EV_OFF = 2'd1;
    localparam logic [1:0] EV_ALL = 2'd2;

    // Increments for notes 120..131 (C9..B9) at 48 kHz, 32-bit accumulator scale.
    function automatic logic [31:0] base_incr(input logic [3:0] k);
        case (k)
            4'd0:    return 32'd749115488;
            4'd1:    return 32'd793660203;
            4'd2:    return 32'd840853752;
            4'd3:    return 32'd890853433;
            4'd4:    return 32'd943826218;
            4'd5:    return 32'd999948913;
            4'd6:    return 32'd1059409156;
            4'd7:    return 32'd1122404694;
            4'd8:    return 32'd1189146696;
            4'd9:    return 32'd1259857069;
            4'd10:   return 32'd1334772036;
            4'd11:   return 32'd1414142136;
            default: return 32'd0;
        endcase
    endfunction

    // Rescale a 32-bit-accumulator increment to the PHASE_BITS accumulator.
    function automatic logic [PHASE_BITS-1:0] scale_incr(input logic [31:0] v);
        logic [PHASE_BITS+31:0] w;
        w = {v, {PHASE_BITS{1'b0}}};
        return w[PHASE_BITS+31:32];
    endfunction

    // ---------------- input decode ----------------
    logic [3:0] in_op;
    logic [3:0] in_chan;
    logic [7:0] in_data1;
    logic [7:0] in_data2;
    logic       chan_ok;
    logic       in_hit;
    logic [1:0] in_kind;

    assign in_op    = midi_event_in[23:20];
    assign in_chan  = midi_event_in[19:16];
    assign in_data1 = midi_event_in[15:8];
    assign in_data2 = midi_event_in[7:0];
    assign chan_ok  = (OMNI != 0) || (in_chan == 4'(CHANNEL));

    always_comb begin
        in_hit  = 1'b0;
        in_kind = EV_ON;
        if (midi_valid_in && chan_ok) begin
            if (in_op == 4'h9 && in_data2 != 8'd0) begin
                in_hit  = 1'b1;
                in_kind = EV_ON;
            end else if (in_op == 4'h8 || in_op == 4'h9) begin
                in_hit  = 1'b1;
                in_kind = EV_OFF;
            end else if (in_op == 4'hB && in_data1 == 8'd123) begin
                in_hit  = 1'b1;
                in_kind = EV_ALL;
            end
        end
    end

    // ---------------- state ----------------
    logic [1:0]       state_reg;
    logic [IDX_W-1:0] scan_idx_reg;
    logic [1:0]       lat_kind_reg;
    logic [6:0]       lat_note_reg;
    logic [6:0]       lat_vel_reg;
    logic             buf_valid_reg;
    logic [1:0]       buf_kind_reg;
    logic [6:0]       buf_note_reg;
    logic [6:0]       buf_vel_reg;
    logic             match_found_reg;
    logic [IDX_W-1:0] match_idx_reg;
    logic             free_found_reg;
    logic [IDX_W-1:0] free_idx_reg;
    logic [IDX_W-1:0] oldest_idx_reg;
    logic             overflow_reg;

    logic [N_VOICES-1:0]   gate_reg;
    logic [6:0]            note_reg [N_VOICES];
    logic [7:0]            vol_reg  [N_VOICES];
    logic [PHASE_BITS-1:0] incr_reg [N_VOICES];
    logic [IDX_W-1:0]      rank_reg [N_VOICES];

    // A new event may start in IDLE or straight out of COMMIT, so the
    // buffered event costs no extra idle cycle.
    logic can_start;
    logic start_buf;
    logic start_in;
    logic store_in;
    logic drop_in;

    assign can_start = (state_reg == ST_IDLE) || (state_reg == ST_COMMIT);
    assign start_buf = can_start && buf_valid_reg;
    assign start_in  = can_start && !buf_valid_reg && in_hit;
    assign store_in  = in_hit && (can_start ? buf_valid_reg : !buf_valid_reg);
    assign drop_in   = in_hit && !can_start && buf_valid_reg;
    assign ready_out = (state_reg == ST_IDLE) && !buf_valid_reg;

    // ---------------- commit decision ----------------
    logic [IDX_W-1:0]      tgt_idx;
    logic                  tgt_ok;
    logic                  on_drop;
    logic [IDX_W-1:0]      tgt_rank;
    logic                  commit_on;
    logic                  commit_off;
    logic                  commit_all;
    logic                  steal_drop;
    logic [3:0]            note_div;
    logic [3:0]            note_mod;
    logic [PHASE_BITS-1:0] new_incr;

    always_comb begin
        tgt_idx = oldest_idx_reg;
        tgt_ok  = 1'b0;
        on_drop = 1'b0;
        if (match_found_reg) begin
            tgt_idx = match_idx_reg;
            tgt_ok  = 1'b1;
        end else if (free_found_reg) begin
            tgt_idx = free_idx_reg;
            tgt_ok  = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
            tgt_ok  = 1'b1;
`else
            on_drop = 1'b1;
`endif
        end
    end

    assign tgt_rank   = rank_reg[tgt_idx];
    assign commit_on  = (state_reg == ST_COMMIT) && (lat_kind_reg == EV_ON) && tgt_ok;
    assign commit_off = (state_reg == ST_COMMIT) && (lat_kind_reg == EV_OFF) && match_found_reg;
    assign commit_all = (state_reg == ST_COMMIT) && (lat_kind_reg == EV_ALL);
    assign steal_drop = (state_reg == ST_COMMIT) && (lat_kind_reg == EV_ON) && on_drop;

    // Octave shift: notes 120..127 use the table directly, each octave below halves it.
    assign note_div = 4'(lat_note_reg / 7'd12);
    assign note_mod = 4'(lat_note_reg % 7'd12);
    assign new_incr = scale_incr(base_incr(note_mod)) >> (4'd10 - note_div);

    // ---------------- control FSM, buffer and scan ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg       <= ST_IDLE;
            scan_idx_reg    <= '0;
            lat_kind_reg    <= EV_ON;
            lat_note_reg    <= '0;
            lat_vel_reg     <= '0;
            buf_valid_reg   <= 1'b0;
            buf_kind_reg    <= EV_ON;
            buf_note_reg    <= '0;
            buf_vel_reg     <= '0;
            match_found_reg <= 1'b0;
            match_idx_reg   <= '0;
            free_found_reg  <= 1'b0;
            free_idx_reg    <= '0;
            oldest_idx_reg  <= '0;
            overflow_reg    <= 1'b0;
        end else begin
            overflow_reg <= drop_in || steal_drop;

            if (store_in) begin
                buf_valid_reg <= 1'b1;
                buf_kind_reg  <= in_kind;
                buf_note_reg  <= in_data1[6:0];
                buf_vel_reg   <= in_data2[6:0];
            end else if (start_buf) begin
                buf_valid_reg <= 1'b0;
            end

            if (start_buf || start_in) begin
                state_reg       <= ST_SCAN;
                scan_idx_reg    <= '0;
                match_found_reg <= 1'b0;
                free_found_reg  <= 1'b0;
                lat_kind_reg    <= start_buf ? buf_kind_reg : in_kind;
                lat_note_reg    <= start_buf ? buf_note_reg : in_data1[6:0];
                lat_vel_reg     <= start_buf ? buf_vel_reg  : in_data2[6:0];
            end else if (state_reg == ST_SCAN) begin
                if (!match_found_reg && gate_reg[scan_idx_reg] &&
                    note_reg[scan_idx_reg] == lat_note_reg) begin
                    match_found_reg <= 1'b1;
                    match_idx_reg   <= scan_idx_reg;
                end
                if (!free_found_reg && !gate_reg[scan_idx_reg]) begin
                    free_found_reg <= 1'b1;
                    free_idx_reg   <= scan_idx_reg;
                end
                if (rank_reg[scan_idx_reg] == IDX_W'(N_VOICES - 1)) begin
                    oldest_idx_reg <= scan_idx_reg;
                end
                if (scan_idx_reg == IDX_W'(N_VOICES - 1)) begin
                    state_reg <= ST_COMMIT;
                end else begin
                    scan_idx_reg <= scan_idx_reg + 1'b1;
                end
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

    // ---------------- voice registers and LRU ranks ----------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            gate_reg <= '0;
            for (int i = 0; i < N_VOICES; i++) begin
                note_reg[i] <= '0;
                vol_reg[i]  <= '0;
                incr_reg[i] <= '0;
                rank_reg[i] <= IDX_W'(i);
            end
        end else begin
            for (int i = 0; i < N_VOICES; i++) begin
                if (commit_all || (commit_off && match_idx_reg == IDX_W'(i))) begin
                    gate_reg[i] <= 1'b0;
                    vol_reg[i]  <= '0;
                end else if (commit_on && tgt_idx == IDX_W'(i)) begin
                    gate_reg[i] <= 1'b1;
                    note_reg[i] <= lat_note_reg;
                    vol_reg[i]  <= {lat_vel_reg, 1'b0};
                    incr_reg[i] <= new_incr;
                end
                if (commit_on) begin
                    if (tgt_idx == IDX_W'(i)) begin
                        rank_reg[i] <= '0;
                    end else if (rank_reg[i] < tgt_rank) begin
                        rank_reg[i] <= rank_reg[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign overflow_out = overflow_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N_VOICES; gi++) begin : g_voice_out
            assign gate_out[gi]                                   = gate_reg[gi];
            assign note_out[gi*7 +: 7]                            = note_reg[gi];
            assign vol_out[gi*8 +: 8]                             = vol_reg[gi];
            assign phase_incr_out[gi*PHASE_BITS +: PHASE_BITS]    = incr_reg[gi];
        end
    endgenerate

endmodule
